add32_seq_ctrl: RTL and testbench

Sequencing controller that performs a WIDTH-bit addition by time-multiplexing one SLICE-bit carry-lookahead slice over WIDTH/SLICE cycles, least-significant slice first. It sits between an operand producer and a result consumer, each with its own valid/ready handshake. It owns the ripple carry between slices and assembles the full-width sum. One operation is in flight at a time.

---
 rtl/add_pkg.sv | 13 +
 rtl/cla_slice.sv | 32 +++
 rtl/add32_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_add32_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and default sizing for the sliced adder sequencer.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int SLICE_DEF = 8;

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice: generate/propagate,
// lookahead carries, sum bits and slice carry-out.
module cla_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_c,
    output logic [SLICE-1:0] o_s,
    output logic             o_c
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a | i_b;

    // Carry chain is kept local to the block so each carry is a pure
    // function of g/p and the slice carry-in.
    always_comb begin : carry_chain
        logic [SLICE:0] c;
        c    = '0;
        c[0] = i_c;
        for (int k = 0; k < SLICE; k++) begin
            c[k+1] = w_g[k] | (w_p[k] & c[k]);
        end
        o_s = i_a ^ i_b ^ c[SLICE-1:0];
        o_c = c[SLICE];
    end

endmodule

// File: rtl/add32_seq_ctrl.sv
// Time-multiplexed WIDTH-bit adder: one cla_slice is reused over WIDTH/SLICE
// cycles, least-significant slice first, behind valid/ready handshakes.
module add32_seq_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_s_sl;
    logic             w_c_sl;

    // Select the operand slice addressed by the current index.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int j = 0; j < NSLICE; j++) begin
            if (r_idx == IDX_W'(j)) begin
                w_a_sl = r_a[j*SLICE +: SLICE];
                w_b_sl = r_b[j*SLICE +: SLICE];
            end
        end
    end

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a (w_a_sl),
        .i_b (w_b_sl),
        .i_c (r_carry),
        .o_s (w_s_sl),
        .o_c (w_c_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < NSLICE; j++) begin
                        if (r_idx == IDX_W'(j)) begin
                            r_sum[j*SLICE +: SLICE] <= w_s_sl;
                        end
                    end
                    r_carry <= w_c_sl;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_c_sl;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Directed-vector and randomized check of the sliced adder sequencer.
module tb_add32_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    int n_cmp;
    int n_fail;

    add32_seq_ctrl #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) at falling edges until the controller is ready.
    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) chk(name, {63'd0, in_ready}, 64'd1);
    endtask

    // From just after an edge, step edges until out_valid; returns edges waited.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic [32:0] ref33;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        int          w;
        logic        got;

        n_cmp  = 0;
        n_fail = 0;

        tbl[0] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        tbl[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tbl[3] = '{32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 1'b0};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        tbl[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
        tbl[7] = '{32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[8] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        tbl[9] = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        cin       = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum",       {32'd0, sum},       64'd0);
        chk("rst_cout",      {63'd0, cout},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors with out_ready held high.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wait_ready("tbl_ready_timeout");
            a        = tbl[i].a;
            b        = tbl[i].b;
            cin      = tbl[i].cin;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = $urandom;
            b        = $urandom;
            cin      = 1'($urandom_range(0, 1));
            wait_valid(lat);
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("tbl%0d_sum", i), {32'd0, sum}, {32'd0, tbl[i].sum});
            chk($sformatf("tbl%0d_cout", i), {63'd0, cout}, {63'd0, tbl[i].cout});
        end

        // Back-pressure: result must hold while out_ready is low.
        @(negedge clk);
        wait_ready("bp_ready_timeout");
        out_ready = 1'b0;
        a = 32'h80000000; b = 32'h80000000; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp_hold%0d_sum", k), {32'd0, sum}, 64'd0);
            chk($sformatf("bp_hold%0d_cout", k), {63'd0, cout}, 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready},  64'd1);

        // in_valid held high with moving operands during RUN and DONE.
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        w = 0;
        while (out_valid !== 1'b1 && w < 30) begin
            @(negedge clk);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            w++;
        end
        chk("ign_latency", 64'(w), 64'd4);
        chk("ign_sum",  {32'd0, sum},  64'h33333333);
        chk("ign_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        a = 32'h5; b = 32'h6; cin = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ign_u_valid", {63'd0, out_valid}, 64'd0);
        chk("ign_u_ready", {63'd0, in_ready},  64'd1);
        @(posedge clk);
        #1;
        chk("ign_u1_accept", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("ign_second_latency", 64'(lat), 64'd4);
        chk("ign_second_sum", {32'd0, sum}, 64'hB);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        wait_ready("rst_ready_timeout");
        a = 32'h12345678; b = 32'h87654321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_slice0", {56'd0, sum[7:0]}, 64'h99);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready},  64'd1);
        chk("mid_rst_sum",   {32'd0, sum},       64'd0);
        chk("mid_rst_cout",  {63'd0, cout},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a = 32'h1; b = 32'h1; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_sum", {32'd0, sum}, 64'h3);

        // Random back-to-back operations with random back-pressure.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            wait_ready("rnd_ready_timeout");
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            ref33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            a = ra; b = rb; cin = rc; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid === 1'b1 && out_ready) begin
                    chk($sformatf("rnd%0d", n), {31'd0, cout, sum}, {31'd0, ref33});
                    got = 1'b1;
                end
                @(posedge clk);
            end
            if (!got) chk($sformatf("rnd%0d_timeout", n), 64'd0, 64'd1);
        end
        out_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
